// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: opcode constants, fetch FSM states
// and the fetch-buffer entry layout.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0]      OPC_RTYPE = 6'h00;
    localparam logic [5:0]      OPC_LUI   = 6'h0F;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        FULL
    } fetchState_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetchEntry_t;

    function automatic logic [5:0] opcodeOf(input logic [XLEN-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry fetch buffer: the head register drives the decode interface
// directly, the tail register absorbs one word of backpressure.
module fetch_skid_fifo
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  fetchEntry_t pushEntry,
    input  logic        pop,
    output fetchEntry_t headEntry,
    output logic        headValid,
    output logic [1:0]  count
);

    fetchEntry_t headReg;
    fetchEntry_t tailReg;
    logic [1:0]  countReg;
    logic [1:0]  countNext;
    logic        doPop;
    logic        doPush;
    logic        loadHeadNew;
    logic        loadHeadTail;
    logic        loadTail;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        doPop        = pop && (countReg != 2'd0);
        doPush       = push && ((countReg != 2'd2) || doPop);
        loadHeadNew  = doPush && ((countReg == 2'd0) || ((countReg == 2'd1) && doPop));
        loadHeadTail = doPop && (countReg == 2'd2);
        loadTail     = doPush && (((countReg == 2'd1) && !doPop) || (countReg == 2'd2));
        countNext    = countReg + {1'b0, doPush} - {1'b0, doPop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countReg <= 2'd0;
            headReg  <= '{instr: INSTR_NOP, pc: RESET_PC};
        end else if (flush) begin
            countReg <= 2'd0;
        end else begin
            countReg <= countNext;
            if (loadHeadNew) begin
                headReg <= pushEntry;
            end else if (loadHeadTail) begin
                headReg <= tailReg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && loadTail) begin
            tailReg <= pushEntry;
        end
    end

    assign headEntry = headReg;
    assign headValid = (countReg != 2'd0);
    assign count     = countReg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds decode through a two-entry buffer; redirects flush and refetch.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [5:0]      if_opcode,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] drainAddr;
    logic [XLEN-1:0] drainAddrNext;
    logic            ackSeen;
    logic            popEn;
    logic            pushEn;
    logic            flushEn;
    logic [1:0]      fifoCount;
    logic [1:0]      occAfterPush;
    logic            headValid;
    fetchEntry_t     headEntry;
    fetchEntry_t     pushEntry;

    // An ack is only meaningful while a request is actually outstanding.
    assign imem_req     = (state == REQ) || (state == DRAIN);
    assign ackSeen      = imem_ack && imem_req;
    assign popEn        = headValid && if_ready;
    assign imem_addr    = (state == DRAIN) ? drainAddr : pc;
    assign pushEntry    = '{instr: imem_rdata, pc: pc};
    assign occAfterPush = fifoCount + 2'd1 - {1'b0, popEn};

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        drainAddrNext = drainAddr;
        pushEn        = 1'b0;
        flushEn       = 1'b0;
        if (redirect) begin
            flushEn = 1'b1;
            pcNext  = alignWord(redirect_pc);
            // An unanswered request must still be drained; its address stays on the bus.
            case (state)
                REQ: begin
                    if (ackSeen) begin
                        stateNext = REQ;
                    end else begin
                        stateNext     = DRAIN;
                        drainAddrNext = pc;
                    end
                end
                DRAIN:   stateNext = ackSeen ? REQ : DRAIN;
                default: stateNext = REQ;
            endcase
        end else begin
            case (state)
                IDLE: stateNext = REQ;
                REQ: begin
                    if (ackSeen) begin
                        pushEn = 1'b1;
                        pcNext = pc + 32'd4;
                        if (occAfterPush == 2'd2) begin
                            stateNext = FULL;
                        end
                    end
                end
                DRAIN: begin
                    if (ackSeen) begin
                        stateNext = REQ;
                    end
                end
                FULL: begin
                    if (popEn) begin
                        stateNext = REQ;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drainAddr <= RESET_PC;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            drainAddr <= drainAddrNext;
        end
    end

    fetch_skid_fifo #(
        .RESET_PC(RESET_PC)
    ) uFifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flushEn),
        .push      (pushEn),
        .pushEntry (pushEntry),
        .pop       (popEn),
        .headEntry (headEntry),
        .headValid (headValid),
        .count     (fifoCount)
    );

    assign if_valid  = headValid;
    assign if_instr  = headEntry.instr;
    assign if_pc     = headEntry.pc;
    assign if_opcode = opcodeOf(headEntry.instr);

endmodule
